pipe_issue_ctrl: RTL and testbench



---
 rtl/pipe_issue_ctrl_pkg.sv | 16 +
 rtl/pipe_issue_ctrl_arbiter.sv | 41 ++++
 rtl/pipe_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_issue_ctrl_pkg.sv
// rtl/pipe_issue_ctrl_pkg.sv - shared state encoding and sizing helpers for the issue/flush controller
package pipe_issue_ctrl_pkg;

  localparam int CTRL_STATE_WIDTH = 1;

  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    CTRL_RUN   = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_t;

  // Width of the flush down-counter: must hold the value NUM_STAGES.
  function automatic int flush_cnt_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_arbiter.sv
// rtl/pipe_issue_ctrl_arbiter.sv - two-way round-robin arbiter with registered last-grant pointer
module issue_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic grant_en,
  output logic grant0,
  output logic grant1
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie.
  logic last_grant;

  // Grant selection: a sole requester always wins, a tie goes to the one not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (grant_en) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Pointer moves only on a completed handshake (grants already include valid).
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - request issue, ID allocation, global stall and flush sweep control
module pipe_issue_ctrl
  import pipe_issue_ctrl_pkg::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  output logic                     req1_ready,
  output logic [ID_WIDTH-1:0]      req_id,
  input  logic                     cancel_valid,
  input  logic [ID_WIDTH-1:0]      cancel_id,
  output logic                     cancel_ready,
  output logic                     pipe_in_valid,
  output logic [ADDRESS_WIDTH-1:0] pipe_in_address,
  output logic [ID_WIDTH-1:0]      pipe_in_id,
  output logic                     pipe_flush,
  output logic [ID_WIDTH-1:0]      pipe_flush_id,
  output logic                     pipe_stall,
  input  logic                     tail_valid,
  input  logic                     sink_ready,
  output logic                     busy
);

  localparam int FLUSH_CNT_WIDTH = flush_cnt_width(NUM_STAGES);
  localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(NUM_STAGES);
  localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LAST = FLUSH_CNT_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]        ID_FIRST   = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]        ID_LAST    = '1;

  ctrl_state_t                state;
  ctrl_state_t                state_next;
  logic [FLUSH_CNT_WIDTH-1:0] flush_cnt;
  logic [ID_WIDTH-1:0]        next_id;
  logic                       cancel_fire;
  logic                       flush_start;
  logic                       issue_en;
  logic                       grant0;
  logic                       grant1;
  logic                       issue;

  assign cancel_ready = (state == CTRL_RUN);
  assign cancel_fire  = cancel_valid & cancel_ready;
  // A cancel for ID 0 names no transaction: accepted but nothing to sweep.
  assign flush_start  = cancel_fire & (cancel_id != '0);
  assign pipe_stall   = (state == CTRL_FLUSH) | (tail_valid & ~sink_ready);
  assign issue_en     = (state == CTRL_RUN) & ~pipe_stall & ~cancel_fire;
  assign busy         = (state == CTRL_FLUSH);

  issue_rr_arbiter u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .grant_en   (issue_en),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign issue      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Stage-0 drive: winner's address and the next ID, all zero when nothing issues.
  always_comb begin
    pipe_in_valid   = issue;
    pipe_in_address = '0;
    pipe_in_id      = '0;
    if (grant0) begin
      pipe_in_address = req0_address;
    end else if (grant1) begin
      pipe_in_address = req1_address;
    end
    if (issue) begin
      pipe_in_id = next_id;
    end
    req_id = pipe_in_id;
  end

  // Next state: leave RUN on a real cancel, leave FLUSH once the stall window is spent.
  always_comb begin
    state_next = state;
    case (state)
      CTRL_RUN: begin
        if (flush_start) begin
          state_next = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        if (flush_cnt <= FLUSH_LAST) begin
          state_next = CTRL_RUN;
        end
      end
      default: state_next = CTRL_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CTRL_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Stall window counter: one count per stage so the flush pulse can walk the whole chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (flush_start) begin
      flush_cnt <= FLUSH_LOAD;
    end else if ((state == CTRL_FLUSH) && (flush_cnt != '0)) begin
      flush_cnt <= flush_cnt - FLUSH_LAST;
    end
  end

  // One-cycle flush pulse carrying the cancelled ID into the stage-0 flush inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_flush    <= 1'b0;
      pipe_flush_id <= '0;
    end else begin
      pipe_flush    <= flush_start;
      pipe_flush_id <= flush_start ? cancel_id : '0;
    end
  end

  // ID allocator: skips 0 on wrap because empty stages carry ID 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_id <= ID_FIRST;
    end else if (issue) begin
      next_id <= (next_id == ID_LAST) ? ID_FIRST : next_id + ID_FIRST;
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - scoreboard bench for pipe_issue_ctrl with a stand-in pipeline
module tb_pipe_issue_ctrl;

  localparam int NS = 4;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int ID_SPAN = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_address = '0, req1_address = '0;
  logic          req0_ready, req1_ready;
  logic [IW-1:0] req_id;
  logic          cancel_valid = 1'b0;
  logic [IW-1:0] cancel_id = '0;
  logic          cancel_ready;
  logic          pipe_in_valid;
  logic [AW-1:0] pipe_in_address;
  logic [IW-1:0] pipe_in_id;
  logic          pipe_flush;
  logic [IW-1:0] pipe_flush_id;
  logic          pipe_stall;
  logic          tail_valid;
  logic          sink_ready = 1'b1;
  logic          busy;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.NUM_STAGES(NS), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_ready(req1_ready),
    .req_id(req_id),
    .cancel_valid(cancel_valid), .cancel_id(cancel_id), .cancel_ready(cancel_ready),
    .pipe_in_valid(pipe_in_valid), .pipe_in_address(pipe_in_address), .pipe_in_id(pipe_in_id),
    .pipe_flush(pipe_flush), .pipe_flush_id(pipe_flush_id), .pipe_stall(pipe_stall),
    .tail_valid(tail_valid), .sink_ready(sink_ready), .busy(busy)
  );

  typedef struct {
    bit          chk;
    bit          r0r;
    bit          r1r;
    bit          in_v;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    bit          flush;
    logic [IW-1:0] fid;
    bit          stall;
    bit          busy;
    bit          cready;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] exp_deliv[$];
  logic [IW-1:0] inflight[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: remaining stall cycles, tie preference, issue count, pending pulse.
  int flush_left = 0;
  int prefer = 0;
  int issued = 0;
  int pulse_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in pipeline: NS stages frozen by stall, flush chain always moving.
  logic [IW-1:0] stage_id [NS];
  logic [IW-1:0] chain_q [NS];
  logic          cap_stall, cap_in_valid;
  logic [IW-1:0] cap_in_id, cap_flush_id;

  assign tail_valid = (stage_id[NS-1] != '0);

  function automatic logic [IW-1:0] sweep_at(input int k);
    return (k == 0) ? cap_flush_id : chain_q[k];
  endfunction

  // Capture DUT outputs mid-cycle for the pipeline stand-in.
  initial forever begin
    @(negedge clk);
    #3;
    cap_stall    = pipe_stall;
    cap_in_valid = pipe_in_valid;
    cap_in_id    = pipe_in_id;
    cap_flush_id = pipe_flush_id;
  end

  // Pipeline stand-in and tail monitor.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) begin
        stage_id[k] <= '0;
        chain_q[k]  <= '0;
      end
    end else begin
      for (int k = 1; k < NS; k++) chain_q[k] <= sweep_at(k - 1);
      if (cap_stall) begin
        for (int k = 0; k < NS; k++)
          if (sweep_at(k) != '0 && sweep_at(k) == stage_id[k]) stage_id[k] <= '0;
      end else begin
        if (tail_valid)
          check("tail_id", 64'(stage_id[NS-1]),
                exp_deliv.size() > 0 ? 64'(exp_deliv.pop_front()) : 64'hffff);
        for (int k = 1; k < NS; k++) stage_id[k] <= stage_id[k-1];
        stage_id[0] <= cap_in_valid ? cap_in_id : '0;
      end
    end
  end

  // Output monitor: pops one expectation per cycle and compares.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        check("grant", 64'({req0_ready, req1_ready, req_id}), 64'({e.r0r, e.r1r, e.id}));
        check("pipe_in", 64'({pipe_in_valid, pipe_in_id, pipe_in_address}), 64'({e.in_v, e.id, e.addr}));
        check("flush", 64'({pipe_flush, pipe_flush_id}), 64'({e.flush, e.fid}));
        check("ctrl", 64'({pipe_stall, busy, cancel_ready}), 64'({e.stall, e.busy, e.cready}));
      end
    end
  end

  // Drive one cycle of stimulus and push the reference expectation.
  task automatic step(input bit r0, input int a0, input bit r1, input int a1,
                      input bit cv, input int cid, input bit sr, input bit rst);
    exp_t e;
    bit busy_e, stall_e, cfire, iss;
    int win, id_e;
    @(negedge clk);
    reset = rst;
    req0_valid = r0; req0_address = AW'(a0);
    req1_valid = r1; req1_address = AW'(a1);
    cancel_valid = cv; cancel_id = IW'(cid);
    sink_ready = sr;
    #1;
    e = '{default: 0};
    if (rst) begin
      exp_q.push_back(e);
      flush_left = 0; prefer = 0; issued = 0; pulse_id = 0;
      inflight.delete();
      exp_deliv.delete();
      return;
    end
    busy_e  = (flush_left > 0);
    stall_e = busy_e || (tail_valid && !sr);
    cfire   = cv && !busy_e;
    iss     = !stall_e && !cfire && (r0 || r1);
    win     = (r0 && r1) ? prefer : (r0 ? 0 : 1);
    id_e    = (issued % ID_SPAN) + 1;
    e.chk   = 1;
    e.r0r   = iss && win == 0;
    e.r1r   = iss && win == 1;
    e.in_v  = iss;
    e.id    = iss ? IW'(id_e) : '0;
    e.addr  = iss ? AW'(win ? a1 : a0) : '0;
    e.flush = (pulse_id != 0);
    e.fid   = IW'(pulse_id);
    e.stall = stall_e;
    e.busy  = busy_e;
    e.cready = !busy_e;
    exp_q.push_back(e);
    if (!stall_e && tail_valid)
      exp_deliv.push_back(inflight.size() > 0 ? inflight.pop_front() : '0);
    pulse_id = 0;
    if (busy_e) flush_left--;
    if (cfire && cid != 0) begin
      pulse_id = cid;
      flush_left = NS;
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i] == IW'(cid)) inflight.delete(i);
    end
    if (iss) begin
      inflight.push_back(IW'(id_e));
      issued++;
      prefer = 1 - win;
    end
  endtask

  initial begin
    int cid;
    int sel;
    // reset and reset-state outputs
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    // single request, then next ID
    step(1, 'h10, 0, 0, 0, 0, 1, 0);
    step(1, 'h20, 0, 0, 0, 0, 1, 0);
    // contention
    for (int i = 0; i < 4; i++) step(1, 'h100 + i, 1, 'h200 + i, 0, 0, 1, 0);
    // backpressure with a valid tail, then release
    for (int i = 0; i < 3; i++) step(1, 'h30, 1, 'h40, 0, 0, 0, 0);
    step(1, 'h30, 1, 'h40, 0, 0, 1, 0);
    // issue three more, cancel the middle one together with a req0
    for (int i = 0; i < 3; i++) step(1, 'h50 + i, 0, 0, 0, 0, 1, 0);
    cid = (inflight.size() > 1) ? int'(inflight[inflight.size() - 2]) : 1;
    step(1, 'h60, 0, 0, 1, cid, 1, 0);
    for (int i = 0; i < NS + 2; i++) step(1, 'h61, 1, 'h62, 1, 3, 1, 0);
    // cancel with ID 0 plus req0: no issue, no flush
    step(1, 'h70, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    // reset during FLUSH cycle 2
    step(0, 0, 0, 0, 1, 5, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 'h80, 0, 0, 0, 0, 1, 0);
    // randomized traffic, long enough for several ID wraps
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) cid = 0;
      else if (sel == 1 || inflight.size() == 0) cid = int'($urandom_range(1, ID_SPAN));
      else cid = int'(inflight[$urandom_range(0, inflight.size() - 1)]);
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 16'hffff)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 16'hffff)),
           $urandom_range(0, 19) == 0, cid, $urandom_range(0, 3) != 0, 0);
    end
    // drain, bounded
    for (int i = 0; i < 60 && (inflight.size() > 0 || exp_deliv.size() > 0); i++)
      step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #4;
    check("drain_inflight", 64'(inflight.size()), 64'd0);
    check("drain_deliv", 64'(exp_deliv.size()), 64'd0);
    check("drain_exp", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
